// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the my_mem byte-wide parity memory.
// Define MEM_RR_ARBITER_PARITY_EN to build the parity check and error counter.

module mem_rr_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gnt_set,
  input  logic          rd_done,
  input  logic [DW-1:0] rdata_in,
  input  logic          perr_in,
  output logic          gnt,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          perr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      perr   <= 1'b0;
    end else begin
      gnt    <= gnt_set;
      rvalid <= rd_done;
      // rdata/perr hold between pulses; only the owning requester's copy updates
      if (rd_done) begin
        rdata <= rdata_in;
        perr  <= perr_in;
      end
    end
  end
endmodule

module mem_rr_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_perr,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_perr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW:0]   mem_data_out,
  output logic          busy,
  output logic [7:0]    err_cnt
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t               state;
  cmd_t                 cmd;
  cmd_t [NREQ-1:0]      req_cmd;
  logic [NREQ-1:0]      req;
  logic                 ptr;
  logic                 win;
  logic                 win_id;
  logic                 grant_now;
  logic                 perr_calc;
  logic [NREQ-1:0]      gnt_set, rd_done, gnt, rvalid, perr;
  logic [NREQ-1:0][DW-1:0] rdata;

  assign req        = {b_req, a_req};
  assign req_cmd[0] = {a_we, a_addr, a_wdata};
  assign req_cmd[1] = {b_we, b_addr, b_wdata};

  // B wins when it is alone or when both request and the pointer favours B
  assign win       = b_req & (~a_req | ptr);
  assign grant_now = (state == IDLE) & (|req);

  assign mem_address = cmd.addr;
  assign mem_data_in = cmd.wdata;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      ptr       <= 1'b0;
      win_id    <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: if (grant_now) begin
          cmd       <= req_cmd[win];
          win_id    <= win;
          ptr       <= ~win;
          mem_write <= req_cmd[win].we;
          mem_read  <= ~req_cmd[win].we;
          state     <= ISSUE;
        end
        ISSUE:   state <= cmd.we ? IDLE : CAPT;
        CAPT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RR_ARBITER_PARITY_EN
  assign perr_calc = mem_data_out[DW] ^ (^mem_data_out[DW-1:0]);

  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= 8'd0;
    else if ((state == CAPT) && perr_calc && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_par;
  assign unused_par = mem_data_out[DW];
  assign perr_calc  = 1'b0;
  assign err_cnt    = 8'd0;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign gnt_set[i] = grant_now & (win == 1'(i));
    assign rd_done[i] = (state == CAPT) & (win_id == 1'(i));

    mem_rr_port #(.DW(DW)) u_port (
      .clk      (clk),
      .reset    (reset),
      .gnt_set  (gnt_set[i]),
      .rd_done  (rd_done[i]),
      .rdata_in (mem_data_out[DW-1:0]),
      .perr_in  (perr_calc),
      .gnt      (gnt[i]),
      .rvalid   (rvalid[i]),
      .rdata    (rdata[i]),
      .perr     (perr[i])
    );
  end

  assign a_gnt    = gnt[0];
  assign a_rvalid = rvalid[0];
  assign a_rdata  = rdata[0];
  assign a_perr   = perr[0];
  assign b_gnt    = gnt[1];
  assign b_rvalid = rvalid[1];
  assign b_rdata  = rdata[1];
  assign b_perr   = perr[1];
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural my_mem model.
module tb_mem_rr_arbiter;
`ifdef MEM_RR_ARBITER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = 0, b_addr = 0;
  logic [7:0]  a_wdata = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, a_perr, b_gnt, b_rvalid, b_perr;
  logic [7:0]  a_rdata, b_rdata, err_cnt;
  logic        mem_write, mem_read, busy;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [8:0]  mem_data_out;

  int total = 0;
  int bad   = 0;
  bit inject = 0;

  logic [8:0]  mem_m [256];
  logic [15:0] addr6 [6];
  logic [7:0]  data6 [6];

  always #5 clk = ~clk;

  // my_mem: write captured and read data updated at the edge closing ISSUE
  always @(posedge clk) begin
    if (mem_write) mem_m[mem_address[7:0]] <= {^mem_data_in, mem_data_in};
    if (mem_read)  mem_data_out <= inject ? 9'h181 : mem_m[mem_address[7:0]];
  end

  mem_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_perr(a_perr),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_perr(b_perr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One uncontended command; checks grant, strobe and (for reads) the response.
  task automatic do_cmd(input bit who, input bit we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input bit exp_pe);
    if (who) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else     begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    tick();
    chk("gnt_a", a_gnt, !who);
    chk("gnt_b", b_gnt, who);
    chk("strobe", {mem_write, mem_read}, {we, !we});
    chk("mem_addr", mem_address, addr);
    if (we) chk("mem_din", mem_data_in, wd);
    a_req = 0; b_req = 0;
    tick();
    chk("gnt_drop", a_gnt | b_gnt | mem_write | mem_read, 0);
    if (we) chk("wr_idle_busy", busy, 0);
    else begin
      chk("capt_busy", busy, 1);
      tick();
      chk("rvalid", {a_rvalid, b_rvalid}, who ? 2'b01 : 2'b10);
      chk("rdata", who ? b_rdata : a_rdata, exp_rd);
      chk("perr", who ? b_perr : a_perr, exp_pe);
      chk("rv_idle_busy", busy, 0);
    end
  endtask

  int  mst;
  bit  mptr, mwe, mwid, wb;
  int  order [6] = '{3, 0, 5, 1, 4, 2};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_outs", {a_gnt, a_rvalid, a_perr, b_gnt, b_rvalid, b_perr, mem_write, mem_read, busy}, 0);
    chk("rst_data", {a_rdata, b_rdata, err_cnt}, 0);
    chk("rst_mem", {mem_address, mem_data_in}, 0);
    reset = 0;

    // A-only write then read
    do_cmd(0, 1, 16'h1234, 8'h5A, 8'h00, 0);
    do_cmd(0, 0, 16'h1234, 8'h00, 8'h5A, 0);
    tick();
    chk("a_rv_pulse", a_rvalid, 0);
    chk("a_rdata_hold", a_rdata, 8'h5A);
    chk("b_quiet", {b_gnt, b_rvalid, b_perr, b_rdata}, 0);

    // contention: both hold reads from reset; grants alternate A,B,A,B
    do_cmd(0, 1, 16'h0010, 8'h11, 8'h00, 0);
    do_cmd(1, 1, 16'h0020, 8'h22, 8'h00, 0);
    reset = 1; tick(); reset = 0;
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_gnt", {a_gnt, b_gnt}, k[0] ? 2'b01 : 2'b10);
      chk("cont_rd1", mem_read, 1);
      chk("cont_addr", mem_address, k[0] ? 16'h0020 : 16'h0010);
      tick();
      chk("cont_rd2", {mem_read, mem_write, a_gnt, b_gnt}, 0);
      tick();
      chk("cont_rd3", {mem_read, mem_write}, 0);
      chk("cont_rv", {a_rvalid, b_rvalid}, k[0] ? 2'b01 : 2'b10);
      chk("cont_rdata", k[0] ? b_rdata : a_rdata, k[0] ? 8'h22 : 8'h11);
    end
    a_req = 0; b_req = 0;
    tick();

    // six random writes A,B,A,B,A,B then shuffled reads by the writer
    for (int i = 0; i < 6; i++) begin
      addr6[i] = {8'($urandom), 8'(8'h40 + i)};
      data6[i] = 8'($urandom);
      do_cmd(i[0], 1, addr6[i], data6[i], 8'h00, 0);
    end
    for (int j = 0; j < 6; j++)
      do_cmd(order[j][0], 0, addr6[order[j]], 8'h00, data6[order[j]], 0);
    chk("err_cnt_clean", err_cnt, 0);

    // parity fault injection and saturation
    inject = 1;
    do_cmd(0, 0, 16'h0040, 8'h00, 8'h81, PAR);
    chk("err_cnt_1", err_cnt, PAR ? 8'd1 : 8'd0);
    for (int n = 0; n < 300; n++)
      do_cmd(n[0], 0, 16'h0041, 8'h00, 8'h81, PAR);
    chk("err_cnt_sat", err_cnt, PAR ? 8'd255 : 8'd0);
    inject = 0;

    // reset during CAPT of an A read (pointer was left on B by that grant)
    a_req = 1; a_we = 0; a_addr = 16'h1234;
    tick();
    chk("pre_rst_gnt", a_gnt, 1);
    a_req = 0;
    tick();
    chk("pre_rst_capt", busy, 1);
    reset = 1;
    tick();
    chk("rst_abort_outs", {a_gnt, a_rvalid, a_perr, b_gnt, b_rvalid, b_perr, mem_write, mem_read, busy}, 0);
    chk("rst_abort_data", {a_rdata, b_rdata, err_cnt}, 0);
    chk("rst_abort_mem", {mem_address, mem_data_in}, 0);
    reset = 0;
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    tick();
    chk("post_rst_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 0;
    tick(); tick();
    chk("post_rst_rv", {a_rvalid, a_rdata}, {1'b1, 8'h11});
    tick();
    chk("loser_gnt", {a_gnt, b_gnt}, 2'b01);
    b_req = 0;
    tick(); tick();
    chk("loser_rv", {b_rvalid, b_rdata}, {1'b1, 8'h22});

    // random traffic against a small FSM model: strobe exclusivity and busy
    reset = 1; tick(); reset = 0;
    mst = 0; mptr = 0; mwe = 0; mwid = 0;
    for (int c = 0; c < 1000; c++) begin
      a_req = 1'($urandom); b_req = 1'($urandom);
      a_we = 1'($urandom);  b_we = 1'($urandom);
      a_addr = 16'($urandom); b_addr = 16'($urandom);
      a_wdata = 8'($urandom); b_wdata = 8'($urandom);
      case (mst)
        0: if (a_req | b_req) begin
             wb = b_req & (!a_req | mptr);
             mptr = !wb; mwid = wb; mwe = wb ? b_we : a_we; mst = 1;
           end
        1: mst = mwe ? 0 : 2;
        default: mst = 0;
      endcase
      tick();
      chk("excl", mem_write & mem_read, 0);
      chk("busy", busy, mst != 0);
      chk("rand_strobe", {mem_write, mem_read, a_gnt, b_gnt},
          (mst == 1) ? {mwe, !mwe, !mwid, mwid} : 4'b0000);
    end
    a_req = 0; b_req = 0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
